// File: rtl/axi4lite_pkg.sv
// ----------------------------------------------------------------------------
// axi4lite_pkg
// Shared definitions for the AXI4-Lite requester arbiter:
//   - AXI response codes (RESP_*)
//   - arb_state_t: arbiter transaction phase (idle / issue / wait / done)
// ----------------------------------------------------------------------------
package axi4lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first asserted request at or above
// ptr, wrapping around.
//   req       in   NUM_REQ  request vector
//   ptr       in   IDX_W    highest-priority index this cycle
//   grant     out  NUM_REQ  one-hot grant (zero when no request)
//   grant_idx out  IDX_W    index of the granted requester (0 when none)
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    // Rotating the doubled vector right by ptr puts requester ptr at bit 0,
    // so a plain lowest-bit search implements the wrap-around priority.
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic                 found;
    int                   cand;

    assign req_dbl = {req, req} >> ptr;
    assign req_rot = req_dbl[NUM_REQ-1:0];

    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment, otherwise a latch is inferred.
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_rot[k]) begin
                found = 1'b1;
                cand  = int'(ptr) + k;
                if (cand >= NUM_REQ) begin
                    cand = cand - NUM_REQ;
                end
                grant_idx = IDX_W'(cand);
            end
        end
        if (found) begin
            grant = NUM_REQ'(1) << grant_idx;
        end
    end

endmodule

// File: rtl/axi4lite_req_arbiter.sv
// ----------------------------------------------------------------------------
// axi4lite_req_arbiter
// Shares one AXI4-Lite master engine between NUM_REQ local requesters with
// round-robin arbitration, one outstanding transaction at a time.
//   aclk, aresetn                      clock / async active-low reset
//   req_valid/ready/we/addr/wdata/wstrb per-requester command (packed)
//   rsp_valid/rsp_rdata/rsp_resp       completion pulse to owner + shared data
//   m_cmd_*                            command to the engine (valid/ready)
//   m_rsp_valid/rdata/resp             engine completion pulse
//   err_unexpected                     pulse: engine response while not busy
// ----------------------------------------------------------------------------
module axi4lite_req_arbiter
    import axi4lite_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  req_wstrb,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic [1:0]                       rsp_resp,
    output logic                             m_cmd_valid,
    input  logic                             m_cmd_ready,
    output logic                             m_cmd_we,
    output logic [ADDR_WIDTH-1:0]            m_cmd_addr,
    output logic [DATA_WIDTH-1:0]            m_cmd_wdata,
    output logic [DATA_WIDTH/8-1:0]          m_cmd_wstrb,
    input  logic                             m_rsp_valid,
    input  logic [DATA_WIDTH-1:0]            m_rsp_rdata,
    input  logic [1:0]                       m_rsp_resp,
    output logic                             err_unexpected
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int STRB_W = DATA_WIDTH / 8;

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   owner_q;
    logic [IDX_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic               accept;
    logic               rsp_capture;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // A grant is always to an asserted request, so any request in IDLE is a
    // handshake.
    assign accept = (state_q == ST_IDLE) && (|req_valid);

    // Response taken in WAIT, or in ISSUE when it coincides with cmd ready.
    assign rsp_capture = m_rsp_valid &&
                         ((state_q == ST_WAIT) ||
                          ((state_q == ST_ISSUE) && m_cmd_ready));

    // ---------------- state register ----------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of block order.
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept) state_d = ST_ISSUE;
            ST_ISSUE: if (m_cmd_ready) state_d = m_rsp_valid ? ST_DONE : ST_WAIT;
            ST_WAIT:  if (m_rsp_valid) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            // NOTE: the command/response holding registers are reset (they
            // are plain flops, not a memory) so every output reads 0 in reset.
            ptr_q          <= '0;
            owner_q        <= '0;
            m_cmd_we       <= 1'b0;
            m_cmd_addr     <= '0;
            m_cmd_wdata    <= '0;
            m_cmd_wstrb    <= '0;
            rsp_rdata      <= '0;
            rsp_resp       <= RESP_OKAY;
            err_unexpected <= 1'b0;
        end else begin
            err_unexpected <= m_rsp_valid &&
                              ((state_q == ST_IDLE) || (state_q == ST_DONE));

            if (accept) begin
                owner_q    <= grant_idx;
                ptr_q      <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                                 : grant_idx + 1'b1;
                m_cmd_we   <= req_we[grant_idx];
                m_cmd_addr <= req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                if (req_we[grant_idx]) begin
                    m_cmd_wdata <= req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                    m_cmd_wstrb <= req_wstrb[grant_idx*STRB_W +: STRB_W];
                end else begin
                    m_cmd_wdata <= '0;
                    m_cmd_wstrb <= '0;
                end
            end

            // Write completions carry no data; keep the shared bus clean.
            if (rsp_capture) begin
                rsp_rdata <= m_cmd_we ? '0 : m_rsp_rdata;
                rsp_resp  <= m_rsp_resp;
            end
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        req_ready   = '0;
        rsp_valid   = '0;
        m_cmd_valid = 1'b0;
        // req_ready is combinational from req_valid; gating with aresetn keeps
        // it low while reset is asserted.
        if (aresetn && (state_q == ST_IDLE)) begin
            req_ready = grant;
        end
        if (state_q == ST_ISSUE) begin
            m_cmd_valid = 1'b1;
        end
        if (state_q == ST_DONE) begin
            rsp_valid[owner_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_axi4lite_req_arbiter.sv
// ----------------------------------------------------------------------------
// tb_axi4lite_req_arbiter
// Directed stimulus with a transaction-level reference model of the arbiter,
// compared against the DUT on every falling edge, plus hand-computed literal
// expectations for each scenario.
// ----------------------------------------------------------------------------
module tb_axi4lite_req_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic              aclk;
    logic              aresetn;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_we;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N*SW-1:0]   req_wstrb;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic [1:0]        rsp_resp;
    logic              m_cmd_valid;
    logic              m_cmd_ready;
    logic              m_cmd_we;
    logic [AW-1:0]     m_cmd_addr;
    logic [DW-1:0]     m_cmd_wdata;
    logic [SW-1:0]     m_cmd_wstrb;
    logic              m_rsp_valid;
    logic [DW-1:0]     m_rsp_rdata;
    logic [1:0]        m_rsp_resp;
    logic              err_unexpected;

    int checks = 0;
    int errors = 0;
    int hs_count = 0;

    axi4lite_req_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_we(m_cmd_we),
        .m_cmd_addr(m_cmd_addr), .m_cmd_wdata(m_cmd_wdata), .m_cmd_wstrb(m_cmd_wstrb),
        .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata), .m_rsp_resp(m_rsp_resp),
        .err_unexpected(err_unexpected)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A transaction is "busy" from acceptance until its completion pulse has
    // been shown; "cmd_sent" marks the engine having taken the command and
    // "rsp_due" the cycle in which the owner sees its completion.
    bit            busy, cmd_sent, rsp_due, exp_err;
    int            owner, prio;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata, exp_rdata;
    logic [SW-1:0] exp_wstrb;
    logic [1:0]    exp_resp;

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (prio + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        busy = 0; cmd_sent = 0; rsp_due = 0; exp_err = 0;
        owner = 0; prio = 0;
    endtask

    task automatic model_capture();
        rsp_due   = 1;
        exp_rdata = exp_we ? '0 : m_rsp_rdata;
        exp_resp  = m_rsp_resp;
    endtask

    task automatic model_step();
        int w;
        exp_err = 0;
        if (rsp_due) begin
            rsp_due = 0;
            busy    = 0;
            exp_err = m_rsp_valid;
        end else if (!busy) begin
            exp_err = m_rsp_valid;
            w = pick();
            if (w >= 0) begin
                owner     = w;
                prio      = (w + 1) % N;
                exp_we    = req_we[w];
                exp_addr  = req_addr[w*AW +: AW];
                exp_wdata = req_we[w] ? req_wdata[w*DW +: DW] : '0;
                exp_wstrb = req_we[w] ? req_wstrb[w*SW +: SW] : '0;
                busy      = 1;
                cmd_sent  = 0;
            end
        end else if (!cmd_sent) begin
            if (m_cmd_ready) begin
                cmd_sent = 1;
                if (m_rsp_valid) model_capture();
            end
        end else if (m_rsp_valid) begin
            model_capture();
        end
    endtask

    // Model advances on the rising edge; DUT outputs compared on the falling edge.
    initial begin
        model_reset();
        forever begin
            @(posedge aclk);
            if (!aresetn) model_reset();
            else          model_step();
            @(negedge aclk);
            begin
                logic [N-1:0] e_ready, e_rsp;
                int w;
                if (!aresetn) model_reset();
                w = pick();
                e_ready = (aresetn && !busy && w >= 0) ? (N'(1) << w) : '0;
                e_rsp   = rsp_due ? (N'(1) << owner) : '0;
                check("req_ready", 64'(req_ready), 64'(e_ready));
                check("m_cmd_valid", 64'(m_cmd_valid), 64'(busy && !cmd_sent));
                check("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
                check("err_unexpected", 64'(err_unexpected), 64'(exp_err));
                if (busy && !cmd_sent) begin
                    check("m_cmd_we", 64'(m_cmd_we), 64'(exp_we));
                    check("m_cmd_addr", 64'(m_cmd_addr), 64'(exp_addr));
                    check("m_cmd_wdata", 64'(m_cmd_wdata), 64'(exp_wdata));
                    check("m_cmd_wstrb", 64'(m_cmd_wstrb), 64'(exp_wstrb));
                end
                if (rsp_due) begin
                    check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
                    check("rsp_resp", 64'(rsp_resp), 64'(exp_resp));
                end
            end
        end
    end

    // Command handshake counter.
    always @(posedge aclk) begin
        if (aresetn && m_cmd_valid && m_cmd_ready) hs_count++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    task automatic all_zero(input string tag);
        check({tag, " req_ready"}, 64'(req_ready), 64'h0);
        check({tag, " m_cmd_valid"}, 64'(m_cmd_valid), 64'h0);
        check({tag, " rsp_valid"}, 64'(rsp_valid), 64'h0);
        check({tag, " err"}, 64'(err_unexpected), 64'h0);
        check({tag, " m_cmd_addr"}, 64'(m_cmd_addr), 64'h0);
        check({tag, " m_cmd_wdata"}, 64'(m_cmd_wdata), 64'h0);
        check({tag, " rsp_rdata"}, 64'(rsp_rdata), 64'h0);
        check({tag, " rsp_resp"}, 64'(rsp_resp), 64'h0);
    endtask

    initial begin
        aresetn = 1'b0;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        m_cmd_ready = 1'b0; m_rsp_valid = 1'b0; m_rsp_rdata = '0; m_rsp_resp = '0;
        repeat (3) @(posedge aclk);
        #2;
        all_zero("reset");
        aresetn = 1'b1;

        // Contention: both requesters write continuously -> 0,1,0,1.
        tick();
        req_valid = 2'b11; req_we = 2'b11;
        req_addr  = {32'h0000_0104, 32'h0000_0100};
        req_wdata = {32'h0000_00B1, 32'h0000_00A0};
        req_wstrb = 8'hFF;
        hs_count  = 0;
        #1 check("contention first grant", 64'(req_ready), 64'h1);
        for (int g = 0; g < 4; g++) begin
            tick();
            check("contention cmd_valid", 64'(m_cmd_valid), 64'h1);
            check("contention wdata", 64'(m_cmd_wdata), (g % 2) ? 64'hB1 : 64'hA0);
            check("contention addr", 64'(m_cmd_addr), (g % 2) ? 64'h104 : 64'h100);
            m_cmd_ready = 1'b1;
            tick();
            m_cmd_ready = 1'b0;
            m_rsp_valid = 1'b1; m_rsp_rdata = 32'h55; m_rsp_resp = 2'b00;
            tick();
            m_rsp_valid = 1'b0;
            #1;
            check("contention rsp_valid", 64'(rsp_valid), (g % 2) ? 64'h2 : 64'h1);
            check("contention write rdata", 64'(rsp_rdata), 64'h0);
            tick();
            #1 check("contention next grant", 64'(req_ready), (g % 2) ? 64'h1 : 64'h2);
        end
        req_valid = '0;
        check("contention handshakes", 64'(hs_count), 64'd4);
        tick();

        // Single read from requester 0 (ptr back at 0); stale wdata must not leak.
        req_valid = 2'b01; req_we = 2'b00; req_addr[31:0] = 32'h0000_0010;
        tick();
        req_valid = '0;
        #1;
        check("read cmd_valid", 64'(m_cmd_valid), 64'h1);
        check("read addr", 64'(m_cmd_addr), 64'h10);
        check("read we", 64'(m_cmd_we), 64'h0);
        check("read wdata zero", 64'(m_cmd_wdata), 64'h0);
        check("read wstrb zero", 64'(m_cmd_wstrb), 64'h0);
        tick(); tick();
        check("read cmd held", 64'(m_cmd_valid), 64'h1);
        m_cmd_ready = 1'b1;
        tick();
        m_cmd_ready = 1'b0;
        #1 check("read wait no cmd", 64'(m_cmd_valid), 64'h0);
        tick();
        m_rsp_valid = 1'b1; m_rsp_rdata = 32'hDEAD_BEEF; m_rsp_resp = 2'b00;
        tick();
        m_rsp_valid = 1'b0;
        #1;
        check("read rsp_valid", 64'(rsp_valid), 64'h1);
        check("read rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
        tick();
        #1;
        check("read rsp one cycle", 64'(rsp_valid), 64'h0);
        check("read rdata hold", 64'(rsp_rdata), 64'hDEAD_BEEF);

        // Write from requester 1 with SLVERR response.
        req_valid = 2'b10; req_we = 2'b10;
        req_addr[63:32] = 32'h0000_0020; req_wdata[63:32] = 32'h1234_5678; req_wstrb[7:4] = 4'hF;
        tick();
        req_valid = '0;
        #1;
        check("wr err we", 64'(m_cmd_we), 64'h1);
        check("wr err addr", 64'(m_cmd_addr), 64'h20);
        check("wr err wdata", 64'(m_cmd_wdata), 64'h1234_5678);
        check("wr err wstrb", 64'(m_cmd_wstrb), 64'hF);
        m_cmd_ready = 1'b1;
        tick();
        m_cmd_ready = 1'b0;
        m_rsp_valid = 1'b1; m_rsp_rdata = 32'hCAFE_F00D; m_rsp_resp = 2'b10;
        tick();
        m_rsp_valid = 1'b0;
        #1;
        check("wr err rsp_valid", 64'(rsp_valid), 64'h2);
        check("wr err resp", 64'(rsp_resp), 64'h2);
        check("wr err rdata", 64'(rsp_rdata), 64'h0);
        tick();

        // Same-cycle ready and response: WAIT skipped.
        req_valid = 2'b01; req_we = 2'b00; req_addr[31:0] = 32'h0000_0030;
        tick();
        req_valid = '0;
        m_cmd_ready = 1'b1; m_rsp_valid = 1'b1; m_rsp_rdata = 32'h0BAD_F00D; m_rsp_resp = 2'b01;
        tick();
        m_cmd_ready = 1'b0; m_rsp_valid = 1'b0;
        #1;
        check("same-cycle rsp_valid", 64'(rsp_valid), 64'h1);
        check("same-cycle rdata", 64'(rsp_rdata), 64'h0BAD_F00D);
        check("same-cycle resp", 64'(rsp_resp), 64'h1);
        tick();
        #1 check("same-cycle done", 64'(rsp_valid), 64'h0);

        // Spurious response while IDLE.
        m_rsp_valid = 1'b1; m_rsp_rdata = 32'hFFFF_FFFF;
        tick();
        m_rsp_valid = 1'b0;
        #1;
        check("spurious idle err", 64'(err_unexpected), 64'h1);
        check("spurious idle no rsp", 64'(rsp_valid), 64'h0);
        tick();
        check("spurious idle err clear", 64'(err_unexpected), 64'h0);
        req_valid = 2'b01;
        #1 check("spurious idle still idle", 64'(req_ready), 64'h1);
        req_valid = '0;

        // Spurious response during DONE (requester 1 read).
        req_valid = 2'b10; req_we = 2'b00; req_addr[63:32] = 32'h0000_0040;
        tick();
        req_valid = '0; m_cmd_ready = 1'b1;
        tick();
        m_cmd_ready = 1'b0; m_rsp_valid = 1'b1; m_rsp_rdata = 32'h11;
        tick();
        m_rsp_rdata = 32'h22;
        #1;
        check("done rsp_valid", 64'(rsp_valid), 64'h2);
        check("done rdata", 64'(rsp_rdata), 64'h11);
        tick();
        m_rsp_valid = 1'b0;
        #1;
        check("spurious done err", 64'(err_unexpected), 64'h1);
        check("spurious done no rsp", 64'(rsp_valid), 64'h0);
        check("spurious done rdata kept", 64'(rsp_rdata), 64'h11);
        tick();

        // Reset while WAITing for requester 0; ptr would otherwise favour 1.
        req_valid = 2'b01; req_addr[31:0] = 32'h0000_0050;
        tick();
        m_cmd_ready = 1'b1;
        tick();
        m_cmd_ready = 1'b0;
        req_valid = 2'b11;
        aresetn = 1'b0;
        #1 all_zero("reset in wait");
        tick(); tick();
        aresetn = 1'b1;
        #1 check("post-reset grant", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        check("post-reset no stale rsp", 64'(rsp_valid), 64'h0);
        m_cmd_ready = 1'b1;
        tick();
        m_cmd_ready = 1'b0;
        check("post-reset wait no rsp", 64'(rsp_valid), 64'h0);
        m_rsp_valid = 1'b1; m_rsp_rdata = 32'h77; m_rsp_resp = 2'b00;
        tick();
        m_rsp_valid = 1'b0;
        #1;
        check("post-reset rsp_valid", 64'(rsp_valid), 64'h1);
        check("post-reset rdata", 64'(rsp_rdata), 64'h77);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
